// File: rtl/mpq_cmd_seq_if.sv
// Host-side command handshake and engine-side dispatch bus for mpq_cmd_seq.
// The master modport is the environment (host plus engine); the slave modport is the sequencer.
interface mpq_cmd_seq_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  host_valid;
   logic [2:0]            host_cmd;
   logic [7:0]            host_index;
   logic [DATA_WIDTH-1:0] host_value;
   logic                  host_ready;
   logic                  busy;
   logic                  cmd_valid;
   logic [2:0]            cmd;
   logic [7:0]            index;
   logic [DATA_WIDTH-1:0] value;

   modport master (
      output host_valid, host_cmd, host_index, host_value, busy,
      input  host_ready, cmd_valid, cmd, index, value
   );

   modport slave (
      input  host_valid, host_cmd, host_index, host_value, busy,
      output host_ready, cmd_valid, cmd, index, value
   );
endinterface

// File: rtl/mpq_cmd_seq.sv
// Command FIFO plus dispatch FSM feeding a priority-queue engine one command at a time,
// pacing each dispatch on the engine's busy rise/fall acknowledge.
module mpq_cmd_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   mpq_cmd_seq_if.slave           bus,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   cmd_err,
   output logic [15:0]            issued_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 3 + 8 + DATA_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ENT_W-1:0]      mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  cmd_valid_q, cmd_valid_d;
   logic [2:0]            cmd_q, cmd_d;
   logic [7:0]            index_q, index_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  cmd_err_q, cmd_err_d;
   logic [15:0]           issued_q, issued_d;
   logic                  ready_s, push_s, store_s, pop_s;
   logic [ENT_W-1:0]      head_s;

   assign ready_s = (count_q < DEPTH_C);
   assign push_s  = bus.host_valid && ready_s;
   // Illegal codes still complete the handshake so the host never stalls on them.
   assign store_s = push_s && (bus.host_cmd <= 3'd4);
   assign head_s  = mem_q[rd_ptr_q];

   // Next-state, dispatch and FIFO bookkeeping.
   always_comb begin
      state_d     = state_q;
      cmd_valid_d = 1'b0;
      cmd_d       = cmd_q;
      index_d     = index_q;
      value_d     = value_q;
      issued_d    = issued_q;
      cmd_err_d   = push_s && !store_s;
      pop_s       = 1'b0;

      case (state_q)
         IDLE: begin
            if ((count_q != {CNT_W{1'b0}}) && !bus.busy) begin
               state_d                   = ISSUE;
               pop_s                     = 1'b1;
               cmd_valid_d               = 1'b1;
               {cmd_d, index_d, value_d} = head_s;
               issued_d                  = issued_q + 16'd1;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE:   state_d = WAIT_HI;
         WAIT_HI: begin
            if (bus.busy) state_d = WAIT_LO;
            else          state_d = WAIT_HI;
         end
         WAIT_LO: begin
            if (!bus.busy) state_d = IDLE;
            else           state_d = WAIT_LO;
         end
         default: state_d = IDLE;
      endcase

      if (store_s) wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_s)   rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      else         rd_ptr_d = rd_ptr_q;

      case ({store_s, pop_s})
         2'b10:   count_d = count_q + CNT_W'(1'b1);
         2'b01:   count_d = count_q - CNT_W'(1'b1);
         default: count_d = count_q;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= {PTR_W{1'b0}};
         rd_ptr_q    <= {PTR_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         cmd_valid_q <= 1'b0;
         cmd_q       <= 3'd0;
         index_q     <= 8'd0;
         value_q     <= {DATA_WIDTH{1'b0}};
         cmd_err_q   <= 1'b0;
         issued_q    <= 16'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
         index_q     <= index_d;
         value_q     <= value_d;
         cmd_err_q   <= cmd_err_d;
         issued_q    <= issued_d;
      end
   end

   // FIFO storage; contents are never cleared, the pointers define validity.
   always_ff @(posedge clk) begin
      if (!rst && store_s) begin
         mem_q[wr_ptr_q] <= {bus.host_cmd, bus.host_index, bus.host_value};
      end
   end

   assign bus.host_ready = ready_s;
   assign bus.cmd_valid  = cmd_valid_q;
   assign bus.cmd        = cmd_q;
   assign bus.index      = index_q;
   assign bus.value      = value_q;
   assign fifo_count     = count_q;
   assign cmd_err        = cmd_err_q;
   assign issued_cnt     = issued_q;
endmodule

// File: tb/tb_mpq_cmd_seq.sv
// Directed bench for mpq_cmd_seq: inputs change and outputs are checked on the falling edge.
module tb_mpq_cmd_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  fifo_count;
   logic        cmd_err;
   logic [15:0] issued_cnt;
   int          errors = 0;
   int          checks = 0;

   mpq_cmd_seq_if #(.DATA_WIDTH(8)) bus ();

   mpq_cmd_seq #(.DATA_WIDTH(8), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .fifo_count (fifo_count),
      .cmd_err    (cmd_err),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input logic [2:0] c, input logic [7:0] i, input logic [7:0] v);
      bus.host_valid = 1'b1;
      bus.host_cmd   = c;
      bus.host_index = i;
      bus.host_value = v;
   endtask

   // Wait (bounded) for one dispatch, check it, then play the engine's busy pulse.
   task automatic drain_one(input string tag, input logic [2:0] c, input logic [7:0] i,
                            input logic [7:0] v);
      int n = 0;
      @(negedge clk);
      while (!bus.cmd_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_seen"}, 32'(bus.cmd_valid), 32'd1);
      chk({tag, "_cmd"},  32'(bus.cmd),       32'(c));
      chk({tag, "_idx"},  32'(bus.index),     32'(i));
      chk({tag, "_val"},  32'(bus.value),     32'(v));
      bus.busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.busy = 1'b0;
   endtask

   initial begin
      int pulses;
      int pushed;
      int popped;
      int bc;
      int consec;
      logic prev_cv;
      int q[$];
      int e;

      rst            = 1'b1;
      bus.busy       = 1'b1;
      bus.host_valid = 1'b0;
      bus.host_cmd   = 3'd0;
      bus.host_index = 8'd0;
      bus.host_value = 8'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_count",  32'(fifo_count),    32'd0);
      chk("rst_cv",     32'(bus.cmd_valid), 32'd0);
      chk("rst_cmd",    32'(bus.cmd),       32'd0);
      chk("rst_idx",    32'(bus.index),     32'd0);
      chk("rst_val",    32'(bus.value),     32'd0);
      chk("rst_err",    32'(cmd_err),       32'd0);
      chk("rst_issued", 32'(issued_cnt),    32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.host_ready), 32'd1);

      // Single command held back while the engine is still loading (busy high).
      offer(3'd3, 8'h11, 8'h5A);
      @(negedge clk);
      bus.host_valid = 1'b0;
      chk("single_count", 32'(fifo_count), 32'd1);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(bus.cmd_valid);
      end
      chk("no_dispatch_while_busy", 32'(pulses), 32'd0);
      bus.busy = 1'b0;
      @(negedge clk);
      chk("single_cv",     32'(bus.cmd_valid), 32'd1);
      chk("single_cmd",    32'(bus.cmd),       32'd3);
      chk("single_idx",    32'(bus.index),     32'h11);
      chk("single_val",    32'(bus.value),     32'h5A);
      chk("single_issued", 32'(issued_cnt),    32'd1);
      chk("single_empty",  32'(fifo_count),    32'd0);

      // Busy handshake: 5 cycles low, 10 high, then low; a second command waits its turn.
      offer(3'd1, 8'h22, 8'h33);
      @(negedge clk);
      bus.host_valid = 1'b0;
      chk("hs_no_consec", 32'(bus.cmd_valid), 32'd0);
      chk("hs_count",     32'(fifo_count),    32'd1);
      chk("hs_hold_cmd",  32'(bus.cmd),       32'd3);
      chk("hs_hold_val",  32'(bus.value),     32'h5A);
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         pulses += int'(bus.cmd_valid);
      end
      bus.busy = 1'b1;
      repeat (10) begin
         @(negedge clk);
         pulses += int'(bus.cmd_valid);
      end
      bus.busy = 1'b0;
      @(negedge clk);
      pulses += int'(bus.cmd_valid);
      chk("hs_no_extra", 32'(pulses), 32'd0);
      @(negedge clk);
      chk("hs2_cv",     32'(bus.cmd_valid), 32'd1);
      chk("hs2_cmd",    32'(bus.cmd),       32'd1);
      chk("hs2_idx",    32'(bus.index),     32'h22);
      chk("hs2_val",    32'(bus.value),     32'h33);
      chk("hs2_issued", 32'(issued_cnt),    32'd2);
      bus.busy = 1'b1;

      // Full FIFO with the engine busy; fifth offer held until the first pop.
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         offer(3'(k), 8'(k), 8'(8'hA0 + k));
         @(negedge clk);
      end
      chk("full_count", 32'(fifo_count),     32'd4);
      chk("full_ready", 32'(bus.host_ready), 32'd0);
      offer(3'd4, 8'd4, 8'hA4);
      @(negedge clk);
      chk("full_held",  32'(fifo_count),    32'd4);
      chk("full_no_cv", 32'(bus.cmd_valid), 32'd0);
      bus.busy = 1'b0;
      @(negedge clk);
      chk("full_ready2", 32'(bus.host_ready), 32'd0);
      @(negedge clk);
      chk("full_pop_cv",    32'(bus.cmd_valid),  32'd1);
      chk("full_pop_idx",   32'(bus.index),      32'd0);
      chk("full_pop_val",   32'(bus.value),      32'hA0);
      chk("full_pop_count", 32'(fifo_count),     32'd3);
      chk("full_pop_ready", 32'(bus.host_ready), 32'd1);
      bus.busy = 1'b1;
      @(negedge clk);
      bus.host_valid = 1'b0;
      chk("full_refill", 32'(fifo_count), 32'd4);
      @(negedge clk);
      bus.busy = 1'b0;
      drain_one("full1", 3'd1, 8'd1, 8'hA1);
      drain_one("full2", 3'd2, 8'd2, 8'hA2);
      drain_one("full3", 3'd3, 8'd3, 8'hA3);
      drain_one("full4", 3'd4, 8'd4, 8'hA4);
      chk("full_issued", 32'(issued_cnt), 32'd7);
      chk("full_empty",  32'(fifo_count), 32'd0);

      // Illegal code is consumed without storing and flags cmd_err for one cycle.
      @(negedge clk);
      offer(3'd6, 8'h77, 8'h88);
      @(negedge clk);
      bus.host_valid = 1'b0;
      chk("ill_err",   32'(cmd_err),       32'd1);
      chk("ill_count", 32'(fifo_count),    32'd0);
      chk("ill_cv",    32'(bus.cmd_valid), 32'd0);
      @(negedge clk);
      chk("ill_err_pulse", 32'(cmd_err),       32'd0);
      chk("ill_cv2",       32'(bus.cmd_valid), 32'd0);

      // Simultaneous push/pop at occupancy 2, then ten commands through the wrapping FIFO.
      bus.busy = 1'b1;
      offer(3'd0, 8'h30, 8'h60);
      @(negedge clk);
      offer(3'd1, 8'h31, 8'h61);
      @(negedge clk);
      chk("pp_pre_count", 32'(fifo_count), 32'd2);
      offer(3'd2, 8'h32, 8'h62);
      bus.busy = 1'b0;
      @(negedge clk);
      chk("pp_cv",    32'(bus.cmd_valid), 32'd1);
      chk("pp_idx",   32'(bus.index),     32'h30);
      chk("pp_count", 32'(fifo_count),    32'd2);
      bus.host_valid = 1'b0;
      bus.busy       = 1'b1;
      bc      = 2;
      q       = {1, 2};
      pushed  = 3;
      popped  = 1;
      consec  = 0;
      prev_cv = 1'b1;
      for (int t = 0; t < 300 && popped < 10; t++) begin
         @(negedge clk);
         if (bus.cmd_valid && prev_cv) consec++;
         prev_cv = bus.cmd_valid;
         if (bus.cmd_valid) begin
            e = (q.size() > 0) ? q.pop_front() : -1;
            chk("wrap_order", 32'(bus.index), 32'(8'h30 + e));
            popped++;
            bus.busy = 1'b1;
            bc       = 2;
         end else if (bc > 0) begin
            bc--;
            if (bc == 0) bus.busy = 1'b0;
         end
         if (pushed < 10) begin
            offer(3'(pushed % 5), 8'(8'h30 + pushed), 8'(8'h60 + pushed));
            if (bus.host_ready) begin
               q.push_back(pushed);
               pushed++;
            end
         end else begin
            bus.host_valid = 1'b0;
         end
      end
      chk("wrap_popped", 32'(popped),     32'd10);
      chk("wrap_consec", 32'(consec),     32'd0);
      chk("wrap_issued", 32'(issued_cnt), 32'd17);

      // Reset while in WAIT_LO with three entries queued; a coincident push is dropped.
      bus.busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         offer(3'd3, 8'(8'h50 + k), 8'(8'h70 + k));
         @(negedge clk);
      end
      chk("mid_count", 32'(fifo_count), 32'd3);
      offer(3'd4, 8'h99, 8'h99);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_count",  32'(fifo_count),    32'd0);
      chk("mid_rst_cv",     32'(bus.cmd_valid), 32'd0);
      chk("mid_rst_cmd",    32'(bus.cmd),       32'd0);
      chk("mid_rst_idx",    32'(bus.index),     32'd0);
      chk("mid_rst_val",    32'(bus.value),     32'd0);
      chk("mid_rst_err",    32'(cmd_err),       32'd0);
      chk("mid_rst_issued", 32'(issued_cnt),    32'd0);
      rst            = 1'b0;
      bus.host_valid = 1'b0;
      bus.busy       = 1'b0;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         pulses += int'(bus.cmd_valid);
      end
      chk("mid_no_cv", 32'(pulses), 32'd0);
      offer(3'd2, 8'hC3, 8'hD4);
      @(negedge clk);
      bus.host_valid = 1'b0;
      drain_one("post_rst", 3'd2, 8'hC3, 8'hD4);
      chk("post_rst_issued", 32'(issued_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
